shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one funnel shifter (shift_right) between N_REQ issue ports of the integer pipeline.
//  Round-robin arbitration with valid/ready on every port. Single-pass ops: SLL/SRL/SRA.
//  Two-pass rotates: ROR/ROL, computed as the OR of a right pass and a left pass.
//  Result is registered and returned with its tag and source port over a valid/ready
//  response channel to writeback.
// PARAMETERS
//  LG_W   6  log2 datapath width; W = 1<<LG_W
//  N_REQ  2  number of requesting ports (>=2)
//  TAG_W  6  width of opaque per-op tag (ROB ptr)
// PORTS
//  clk        in   1             clock, rising edge
//  reset_n    in   1             asynchronous, active-low reset
//  req_valid  in   N_REQ         port i has an op
//  req_ready  out  N_REQ         port i op accepted this cycle (valid&ready)
//  req_op     in   N_REQ x 3     shift_pkg::shift_op_t per port
//  req_data   in   N_REQ x W     operand
//  req_dist   in   N_REQ x LG_W  shift distance
//  req_tag    in   N_REQ x TAG_W tag, returned unmodified
//  rsp_valid  out  1             result available
//  rsp_ready  in   1             writeback takes result
//  rsp_data   out  W             result
//  rsp_tag    out  TAG_W         tag of accepted op
//  rsp_src    out  clog2(N_REQ)  port index that issued op
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_src=0.
//    All values take effect immediately on reset_n fall. req_ready is forced 0 while reset_n=0.
//  Ops (shift_op_t):
//    SLL=0: left pass, dist d.
//    SRL=1: right pass, zero fill.
//    SRA=2: right pass, sign fill.
//    ROR=3: right d, then left d.
//    ROL=4: left d, then right d.
//    5..7: reserved; single SRL pass by 0, so rsp_data=req_data.
//  Arbitration: grant = first i with req_valid[i], searching from rr_ptr upward mod N_REQ.
//    On accept of port g: rr_ptr <= (g+1) mod N_REQ. At most one req_ready bit is set.
//  can_accept = (state==IDLE) | (state==HOLD & rsp_ready); req_ready[i] = can_accept & grant==i.
//  States:
//    IDLE -accept single-pass-> HOLD. Shifter result is registered into rsp_data; rsp_valid=1
//      next cycle (latency 1).
//    IDLE -accept rotate-> PASS2. First-pass result goes to a partial reg; op, data, dist, tag
//      are captured.
//    PASS2 -> HOLD. Shifter is driven from the captured operands with the opposite direction.
//      rsp_data <= partial | shift. Latency 2; req_ready=0 in PASS2.
//    HOLD & !rsp_ready: hold. rsp_data, rsp_tag and rsp_src are stable; no accept.
//    HOLD & rsp_ready & accept: next op as from IDLE (back-to-back; 1 result/cycle for
//      single-pass).
//    HOLD & rsp_ready & no accept: -> IDLE; rsp_valid <= 0.
//  Width rules:
//    Distance is used mod W.
//    Left by d drives shifter is_left=1, distance=d.
//    Second rotate pass uses distance (W-d) mod W. For d=0 both passes are identity,
//      so result=data.
//    is_circular is tied 0.
//  Requester operands must be stable only in the accept cycle; all later use is from
//    captured registers.
//  Reset mid-op (PASS2/HOLD): op is dropped; no response is issued after reset release.
//  Simultaneous valids: only the granted port sees ready. Losers hold valid; the round-robin
//    pointer guarantees service within N_REQ accepts.
// STRUCTURE
//  shift_pkg:
//    typedef enum logic [2:0] shift_op_t.
//    localparams SHIFT_OP_W=3, ST_IDLE/ST_PASS2/ST_HOLD.
//  Sub-module rr_arbiter #(N): req vector + ptr -> one-hot grant + index (combinational).
//  One instance of shift_right #(LG_W), driven by a mux:
//    IDLE/HOLD: granted port's operands.
//    PASS2: captured operands.
//  Single always_ff on clk / negedge reset_n for state, rr_ptr, partial, captured
//    operands and rsp_*.
// TESTING (W=64, N_REQ=2)
//  1. SLL port0 data=0x1 dist=63 -> 1 cycle later rsp_data=0x8000_0000_0000_0000,
//     rsp_src=0, tag echoed.
//  2. data=0x8000_0000_0000_0000 dist=4:
//     SRA -> 0xF800_0000_0000_0000; SRL -> 0x0800_0000_0000_0000.
//  3. ROR data=0x1 dist=1 -> rsp 2 cycles after accept = 0x8000_0000_0000_0000.
//     ROL data=0x1234 dist=0 -> 0x1234; busy=1 during PASS2.
//  4. Both ports valid for 8 cycles with SLL, rsp_ready=1 -> grants 0,1,0,1..., one rsp
//     per cycle, tags in grant order.
//  5. rsp_ready=0 for 5 cycles while HOLD -> rsp_valid=1, rsp_data/tag constant,
//     req_ready=0, no accept; release -> next grant that same cycle.
//  6. reset_n low during PASS2 -> rsp_valid=0 and busy=0 without a clock edge;
//     after release no response, first grant to port 0.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encoding and FSM states for the shared shift unit
// Purpose: types and constants imported by shift_unit_arbiter.
// Contents: SHIFT_OP_W, shift_op_t (SLL/SRL/SRA/ROR/ROL, 5..7 reserved), state_t.
package shift_pkg;

  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROR = 3'd3,
    OP_ROL = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS2 = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic is_rotate(input logic [SHIFT_OP_W-1:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant picker
// Purpose: first requester at or above ptr_i (wrapping mod N) wins.
// Ports: req_i request vector, ptr_i search start, grant_o one-hot,
//        idx_o grant index, any_o some request present.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/shift_right.sv
// rtl/shift_right.sv - funnel shifter, right shift with left shifts by bit reversal
// Purpose: one shared W-bit shifter.
// Ports: data_i operand, dist_i distance (mod W), is_left_i direction,
//        is_arith_i sign fill on right shifts, is_circular_i rotate, result_o.
module shift_right #(
  parameter  int LG_W = 6,
  localparam int W    = 1 << LG_W
) (
  input  logic [W-1:0]    data_i,
  input  logic [LG_W-1:0] dist_i,
  input  logic            is_left_i,
  input  logic            is_arith_i,
  input  logic            is_circular_i,
  output logic [W-1:0]    result_o
);

  logic [W-1:0] lo, hi, fun_out;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Left shifts reuse the right funnel on the bit-reversed operand.
  always_comb begin
    lo = is_left_i ? bit_rev(data_i) : data_i;
    if (is_circular_i)                hi = lo;
    else if (is_arith_i && !is_left_i) hi = {W{data_i[W-1]}};
    else                              hi = '0;
    fun_out  = W'({hi, lo} >> dist_i);
    result_o = is_left_i ? bit_rev(fun_out) : fun_out;
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin shared shifter with registered valid/ready response
// Purpose: N_REQ issue ports share one shift_right; rotates take two passes (OR of a
//   right and a left pass), single-pass ops return after one cycle.
// Ports: req_valid/req_ready/req_op/req_data/req_dist/req_tag per port;
//        rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_src response; busy = not idle.
module shift_unit_arbiter
  import shift_pkg::*;
#(
  parameter  int LG_W  = 6,
  parameter  int N_REQ = 2,
  parameter  int TAG_W = 6,
  localparam int W     = 1 << LG_W,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ-1:0][SHIFT_OP_W-1:0]  req_op,
  input  logic [N_REQ-1:0][W-1:0]           req_data,
  input  logic [N_REQ-1:0][LG_W-1:0]        req_dist,
  input  logic [N_REQ-1:0][TAG_W-1:0]       req_tag,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [W-1:0]                      rsp_data,
  output logic [TAG_W-1:0]                  rsp_tag,
  output logic [SRC_W-1:0]                  rsp_src,
  output logic                              busy
);

  state_t                state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [W-1:0]          partial_q, partial_d;
  logic [SHIFT_OP_W-1:0] cap_op_q, cap_op_d;
  logic [W-1:0]          cap_data_q, cap_data_d;
  logic [LG_W-1:0]       cap_dist_q, cap_dist_d;
  logic [TAG_W-1:0]      cap_tag_q, cap_tag_d;
  logic [SRC_W-1:0]      cap_src_q, cap_src_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [W-1:0]          rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]      rsp_tag_q, rsp_tag_d;
  logic [SRC_W-1:0]      rsp_src_q, rsp_src_d;

  logic [N_REQ-1:0]      grant_oh;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  can_accept, accept;

  logic [SHIFT_OP_W-1:0] g_op;
  logic [W-1:0]          g_data;
  logic [LG_W-1:0]       g_dist;
  logic [TAG_W-1:0]      g_tag;

  logic [W-1:0]          sh_data, sh_res;
  logic [LG_W-1:0]       sh_dist;
  logic                  sh_left, sh_arith;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign can_accept = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & rsp_ready);
  assign accept     = can_accept & grant_any;
  assign req_ready  = (can_accept & reset_n) ? grant_oh : '0;

  assign g_op   = req_op[grant_idx];
  assign g_data = req_data[grant_idx];
  assign g_dist = req_dist[grant_idx];
  assign g_tag  = req_tag[grant_idx];

  // PASS2 replays the captured operand in the opposite direction by (W-d) mod W.
  always_comb begin
    sh_data  = g_data;
    sh_dist  = g_dist;
    sh_left  = 1'b0;
    sh_arith = 1'b0;
    if (state_q == ST_PASS2) begin
      sh_data = cap_data_q;
      sh_dist = -cap_dist_q;
      sh_left = (cap_op_q == OP_ROR);
    end else begin
      case (g_op)
        OP_SLL, OP_ROL: sh_left  = 1'b1;
        OP_SRL, OP_ROR: sh_left  = 1'b0;
        OP_SRA:         sh_arith = 1'b1;
        default:        sh_dist  = '0;
      endcase
    end
  end

  shift_right #(.LG_W(LG_W)) u_shift (
    .data_i        (sh_data),
    .dist_i        (sh_dist),
    .is_left_i     (sh_left),
    .is_arith_i    (sh_arith),
    .is_circular_i (1'b0),
    .result_o      (sh_res)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    partial_d   = partial_q;
    cap_op_d    = cap_op_q;
    cap_data_d  = cap_data_q;
    cap_dist_d  = cap_dist_q;
    cap_tag_d   = cap_tag_q;
    cap_src_d   = cap_src_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_src_d   = rsp_src_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
      if (is_rotate(g_op)) begin
        state_d     = ST_PASS2;
        partial_d   = sh_res;
        cap_op_d    = g_op;
        cap_data_d  = g_data;
        cap_dist_d  = g_dist;
        cap_tag_d   = g_tag;
        cap_src_d   = grant_idx;
        rsp_valid_d = 1'b0;
      end else begin
        state_d     = ST_HOLD;
        rsp_valid_d = 1'b1;
        rsp_data_d  = sh_res;
        rsp_tag_d   = g_tag;
        rsp_src_d   = grant_idx;
      end
    end else if (state_q == ST_PASS2) begin
      state_d     = ST_HOLD;
      rsp_valid_d = 1'b1;
      rsp_data_d  = partial_q | sh_res;
      rsp_tag_d   = cap_tag_q;
      rsp_src_d   = cap_src_q;
    end else if ((state_q == ST_HOLD) && rsp_ready) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      partial_q   <= '0;
      cap_op_q    <= '0;
      cap_data_q  <= '0;
      cap_dist_q  <= '0;
      cap_tag_q   <= '0;
      cap_src_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      partial_q   <= partial_d;
      cap_op_q    <= cap_op_d;
      cap_data_q  <= cap_data_d;
      cap_dist_q  <= cap_dist_d;
      cap_tag_q   <= cap_tag_d;
      cap_src_q   <= cap_src_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_src_q   <= rsp_src_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_src   = rsp_src_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - scoreboard bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_op;
  logic [1:0][63:0] req_data;
  logic [1:0][5:0]  req_dist;
  logic [1:0][5:0]  req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [5:0]       rsp_tag;
  logic [0:0]       rsp_src;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  tag;
    logic        src;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_unit_arbiter #(.LG_W(6), .N_REQ(2), .TAG_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_dist  (req_dist),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .rsp_src   (rsp_src),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference semantics straight from the op definitions.
  function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] d, input int s);
    case (op)
      3'd0:    return d << s;
      3'd1:    return d >> s;
      3'd2:    return 64'($signed(d) >>> s);
      3'd3:    return (d >> s) | (d << (64 - s));
      3'd4:    return (d << s) | (d >> (64 - s));
      default: return d;
    endcase
  endfunction

  // Present one op on port p until accepted, then scramble the operands.
  task automatic issue(input int p, input logic [2:0] op, input logic [63:0] d,
                       input logic [5:0] s, input logic [5:0] t);
    bit got = 0;
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_data[p]  = d;
    req_dist[p]  = s;
    req_tag[p]   = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[p]) begin got = 1; break; end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout port%0d: actual=not accepted required=accepted", p);
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    req_op[p]    = 3'($urandom);
    req_data[p]  = {$urandom, $urandom};
    req_dist[p]  = 6'($urandom);
    req_tag[p]   = 6'($urandom);
  endtask

  // Monitor: abstract availability model plus in-order scoreboard.
  bit m_pass2, m_hold;
  int m_ptr;
  initial begin
    m_pass2 = 0; m_hold = 0; m_ptr = 0;
    forever begin
      bit   can;
      int   g;
      logic [1:0] er;
      exp_t e;
      @(negedge clk);
      if (!reset_n) begin
        m_pass2 = 0; m_hold = 0; m_ptr = 0;
        sb.delete();
        continue;
      end
      can = !m_pass2 && (!m_hold || rsp_ready);
      g = -1;
      for (int k = 0; k < 2; k++) begin
        int j;
        j = (m_ptr + k) % 2;
        if (g < 0 && req_valid[j]) g = j;
      end
      er = 2'b00;
      if (can && g >= 0) er[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_hold));
      chk("busy", 64'(busy), 64'(m_pass2 || m_hold));
      if (m_hold) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: actual=response required=none");
        end else begin
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
          chk("rsp_src", 64'(rsp_src), 64'(sb[0].src));
        end
      end
      if (m_hold && rsp_ready) begin
        m_hold = 0;
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (m_pass2) begin
        m_pass2 = 0; m_hold = 1;
      end else if (can && g >= 0) begin
        e.data = ref_shift(req_op[g], req_data[g], int'(req_dist[g]));
        e.tag  = req_tag[g];
        e.src  = 1'(g);
        sb.push_back(e);
        m_ptr = (g + 1) % 2;
        if (req_op[g] == 3'd3 || req_op[g] == 3'd4) m_pass2 = 1;
        else m_hold = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  bit rand_done;

  initial begin
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_op    = '0;
    req_data  = '0;
    req_dist  = '0;
    req_tag   = '0;
    #12;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("reset_rsp_src", 64'(rsp_src), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // SLL edge, SRA/SRL sign handling, rotates incl. distance 0.
    issue(0, 3'd0, 64'h1, 6'd63, 6'd5);
    issue(0, 3'd2, 64'h8000_0000_0000_0000, 6'd4, 6'd6);
    issue(1, 3'd1, 64'h8000_0000_0000_0000, 6'd4, 6'd7);
    issue(0, 3'd3, 64'h1, 6'd1, 6'd8);
    issue(1, 3'd4, 64'h1234, 6'd0, 6'd9);
    issue(1, 3'd6, 64'hDEAD_BEEF, 6'd17, 6'd10);
    repeat (3) @(posedge clk); #1;

    // Contention: both ports streaming SLL.
    fork
      for (int k = 0; k < 4; k++) issue(0, 3'd0, 64'(k + 1), 6'(k), 6'(20 + k));
      for (int k = 0; k < 4; k++) issue(1, 3'd0, 64'(k + 9), 6'(k + 4), 6'(30 + k));
    join
    repeat (3) @(posedge clk); #1;

    // Backpressure for 5 cycles, then the waiting port goes that same cycle.
    rsp_ready = 1'b0;
    fork
      issue(0, 3'd1, 64'hFFFF_0000, 6'd8, 6'd40);
      begin @(posedge clk); #1; issue(1, 3'd0, 64'h3, 6'd2, 6'd41); end
      begin repeat (6) @(posedge clk); #1; rsp_ready = 1'b1; end
    join
    repeat (3) @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    rand_done = 0;
    fork
      begin
        fork
          for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(0, 3'($urandom), {$urandom, $urandom}, 6'($urandom), 6'($urandom));
          end
          for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            issue(1, 3'($urandom), {$urandom, $urandom}, 6'($urandom), 6'($urandom));
          end
        join
        rand_done = 1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        rsp_ready = ($urandom % 4) != 0;
      end
    join
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Reset during PASS2: response dropped, pointer back to port 0.
    issue(0, 3'd3, 64'hF0, 6'd4, 6'd50);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    fork
      issue(0, 3'd0, 64'h5, 6'd1, 6'd51);
      issue(1, 3'd0, 64'h6, 6'd1, 6'd52);
      begin @(negedge clk); chk("post_reset_grant", 64'(req_ready), 64'd1); end
    join
    repeat (4) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
